adder62_arbiter: RTL and testbench

ADDER62_ARBITER -- requirements
Module: adder62_arbiter

---
 rtl/adder62_arbiter_if.sv | 47 ++++
 rtl/adder62_arbiter.sv | 140 ++++++++++++++
 tb/tb_adder62_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/adder62_arbiter_if.sv
// ============================================================================
//  Module      : adder62_arbiter_if
//  Description : Request/result bus for adder62_arbiter. Two requesters each
//                offer a 62-bit A / 17-bit B operand pair. One consumer takes
//                the 63-bit sum, the owning requester id and the op counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adder62_arbiter_if;
  // Requester 0
  logic        req0_valid;
  logic        req0_ready;
  logic [61:0] req0_a;
  logic [16:0] req0_b;
  // Requester 1
  logic        req1_valid;
  logic        req1_ready;
  logic [61:0] req1_a;
  logic [16:0] req1_b;
  // Result side
  logic        res_valid;
  logic        res_ready;
  logic [62:0] res_sum;
  logic        res_id;
  logic [15:0] op_count;

  // Arbiter side: takes requests, produces results
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_id, op_count
  );

  // Environment side: issues requests, consumes results
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_id, op_count
  );
endinterface : adder62_arbiter_if

`default_nettype wire

// File: rtl/adder62_arbiter.sv
// ============================================================================
//  Module      : adder62_arbiter
//  Description : Two requesters share one 62-bit unsigned adder
//                (A 62 bits + zero-extended 17-bit B -> 63-bit sum).
//                IDLE grants and captures operands, CALC registers the sum,
//                DONE holds the result until the consumer takes it.
//                Macro ADDER62_ARB_ROUND_ROBIN_EN: when defined, simultaneous
//                requests alternate (round robin); when undefined, requester 0
//                always wins (fixed priority, no pointer register).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder62_arbiter (
  input  logic                   clk,
  input  logic                   rst,
  adder62_arbiter_if.slave       arb_if
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q;
  logic [1:0]  state_d;

  logic [61:0] a_q;
  logic [16:0] b_q;
  logic        id_q;
  logic [62:0] res_sum_q;
  logic        res_id_q;
  logic [15:0] op_count_q;

  logic        prio1_w;     // requester 1 preferred on contention
  logic        grant_id_w;  // requester currently offered ready in IDLE
  logic        accept_w;    // operand pair captured on this edge
  logic        release_w;   // consumer takes the result on this edge
  logic [62:0] sum_w;

`ifdef ADDER62_ARB_ROUND_ROBIN_EN
  logic ptr_q;

  // Pointer names the preferred requester; it moves away from whoever was just served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (accept_w) begin
      ptr_q <= ~grant_id_w;
    end
  end

  assign prio1_w = ptr_q;
`else
  assign prio1_w = 1'b0;
`endif

  // A lone valid requester always wins; priority only breaks ties
  assign grant_id_w = arb_if.req1_valid & (~arb_if.req0_valid | prio1_w);
  assign accept_w   = (state_q == S_IDLE) &
                      (grant_id_w ? arb_if.req1_valid : arb_if.req0_valid);
  assign release_w  = (state_q == S_DONE) & arb_if.res_ready;

  // The single shared adder; B is zero-extended, carry lands in bit 62
  assign sum_w = {1'b0, a_q} + {46'd0, b_q};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE waits for a grant, CALC lasts one cycle, DONE waits for consumer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_w)  state_d = S_CALC;
      S_CALC:                 state_d = S_DONE;
      S_DONE:  if (release_w) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Output logic: readies only in IDLE, result valid only in DONE
  always_comb begin
    arb_if.req0_ready = 1'b0;
    arb_if.req1_ready = 1'b0;
    arb_if.res_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        arb_if.req0_ready = ~grant_id_w;
        arb_if.req1_ready = grant_id_w;
      end
      S_DONE:  arb_if.res_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture on the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
    end else if (accept_w) begin
      a_q  <= grant_id_w ? arb_if.req1_a : arb_if.req0_a;
      b_q  <= grant_id_w ? arb_if.req1_b : arb_if.req0_b;
      id_q <= grant_id_w;
    end
  end

  // Result registers load in CALC and then hold through DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_sum_q <= '0;
      res_id_q  <= 1'b0;
    end else if (state_q == S_CALC) begin
      res_sum_q <= sum_w;
      res_id_q  <= id_q;
    end
  end

  // Completed-operation counter, wraps silently at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (release_w) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign arb_if.res_sum  = res_sum_q;
  assign arb_if.res_id   = res_id_q;
  assign arb_if.op_count = op_count_q;

endmodule : adder62_arbiter

`default_nettype wire

// File: tb/tb_adder62_arbiter.sv
// ============================================================================
//  Module      : tb_adder62_arbiter
//  Description : Directed self-checking bench for adder62_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder62_arbiter;

  logic clk;
  logic rst;

  adder62_arbiter_if bus ();

  adder62_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          chk_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] exp_cnt = 16'd0;

  // Single comparison point: count it, report a mismatch
  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation given valids already driven: accept, CALC, DONE (+hold), release
  task automatic do_op(input string tag, input logic exp_id, input logic [62:0] exp_sum,
                       input int hold);
    int waited;
    waited = 0;
    while (!((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready))
           && waited < 20) begin
      step();
      waited++;
    end
    if (waited >= 20) begin
      check_eq({tag, "_accept_timeout"}, 64'd0, 64'd1);
      return;
    end
    step();  // CALC
    check_eq({tag, "_calc_valid"}, {63'd0, bus.res_valid}, 64'd0);
    check_eq({tag, "_calc_rdy"}, {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
    step();  // DONE
    check_eq({tag, "_valid"}, {63'd0, bus.res_valid}, 64'd1);
    check_eq({tag, "_sum"}, {1'b0, bus.res_sum}, {1'b0, exp_sum});
    check_eq({tag, "_id"}, {63'd0, bus.res_id}, {63'd0, exp_id});
    check_eq({tag, "_cnt_pre"}, {48'd0, bus.op_count}, {48'd0, exp_cnt});
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq({tag, "_hold_valid"}, {63'd0, bus.res_valid}, 64'd1);
      check_eq({tag, "_hold_sum"}, {1'b0, bus.res_sum}, {1'b0, exp_sum});
      check_eq({tag, "_hold_id"}, {63'd0, bus.res_id}, {63'd0, exp_id});
      check_eq({tag, "_hold_rdy"}, {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
      check_eq({tag, "_hold_cnt"}, {48'd0, bus.op_count}, {48'd0, exp_cnt});
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    check_eq({tag, "_cnt_post"}, {48'd0, bus.op_count}, {48'd0, exp_cnt});
    check_eq({tag, "_post_valid"}, {63'd0, bus.res_valid}, 64'd0);
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
  endtask

  logic exp_seq [4];

  initial begin
    bus.res_ready = 1'b0;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    check_eq("rst_valid", {63'd0, bus.res_valid}, 64'd0);
    check_eq("rst_sum", {1'b0, bus.res_sum}, 64'd0);
    check_eq("rst_id", {63'd0, bus.res_id}, 64'd0);
    check_eq("rst_cnt", {48'd0, bus.op_count}, 64'd0);

    // Single request from requester 0: 5 + 3
    bus.req0_valid = 1'b1;
    bus.req0_a     = 62'd5;
    bus.req0_b     = 17'd3;
    #1;
    check_eq("single_rdy0", {63'd0, bus.req0_ready}, 64'd1);
    check_eq("single_rdy1", {63'd0, bus.req1_ready}, 64'd0);
    do_op("single", 1'b0, 63'd8, 0);
    idle_inputs();

    // Max operands from requester 1: carry into bit 62
    bus.req1_valid = 1'b1;
    bus.req1_a     = 62'h3FFF_FFFF_FFFF_FFFF;
    bus.req1_b     = 17'h1FFFF;
    #1;
    check_eq("ovf_rdy1", {63'd0, bus.req1_ready}, 64'd1);
    do_op("ovf", 1'b1, 63'h4000_0000_0001_FFFE, 0);
    idle_inputs();

    // Backpressure: result held for 10 cycles
    bus.req0_valid = 1'b1;
    bus.req0_a     = 62'h1234_5678_9ABC;
    bus.req0_b     = 17'h10001;
    #1;
    do_op("bp", 1'b0, 63'h1234_5679_9ABD, 10);
    idle_inputs();

    // Valid withdrawn before any edge: nothing captured
    bus.req1_valid = 1'b1;
    bus.req1_a     = 62'd77;
    #1;
    check_eq("wd_rdy1", {63'd0, bus.req1_ready}, 64'd1);
    bus.req1_valid = 1'b0;
    step();
    step();
    step();
    check_eq("wd_valid", {63'd0, bus.res_valid}, 64'd0);
    check_eq("wd_idle", {63'd0, (bus.req0_ready | bus.req1_ready)}, 64'd1);
    check_eq("wd_cnt", {48'd0, bus.op_count}, {48'd0, exp_cnt});

    // Reset during CALC discards the operation
    bus.req0_valid = 1'b1;
    bus.req0_a     = 62'd10;
    bus.req0_b     = 17'd20;
    step();  // accepting edge, now in CALC
    idle_inputs();
    rst = 1'b1;
    #1;
    check_eq("rstmid_valid", {63'd0, bus.res_valid}, 64'd0);
    check_eq("rstmid_cnt", {48'd0, bus.op_count}, 64'd0);
    check_eq("rstmid_sum", {1'b0, bus.res_sum}, 64'd0);
    exp_cnt = 16'd0;
    #2;
    rst = 1'b0;
    step();
    check_eq("rstmid_nores", {63'd0, bus.res_valid}, 64'd0);

    // Contention: both valid for 4 ops (first op also proves recovery after reset)
`ifdef ADDER62_ARB_ROUND_ROBIN_EN
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    bus.req0_valid = 1'b1;
    bus.req0_a     = 62'd1;
    bus.req0_b     = 17'd1;
    bus.req1_valid = 1'b1;
    bus.req1_a     = 62'd7;
    bus.req1_b     = 17'd2;
    #1;
    for (int k = 0; k < 4; k++) begin
      do_op($sformatf("cont%0d", k), exp_seq[k], exp_seq[k] ? 63'd9 : 63'd2, 0);
    end
    idle_inputs();
    step();

    // Counter wrap: preload 0xFFFF, complete one more op
    force dut.op_count_q = 16'hFFFF;
    step();
    release dut.op_count_q;
    #1;
    exp_cnt = 16'hFFFF;
    check_eq("wrap_pre", {48'd0, bus.op_count}, 64'hFFFF);
    bus.req1_valid = 1'b1;
    bus.req1_a     = 62'd100;
    bus.req1_b     = 17'd1;
    #1;
    do_op("wrap", 1'b1, 63'd101, 0);
    idle_inputs();
    check_eq("wrap_zero", {48'd0, bus.op_count}, 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_adder62_arbiter

`default_nettype wire
